// File: rtl/qam_tpg_pkg.sv
// Shared encodings and helpers for the QAM test-pattern generator: modes, FSM states,
// PRBS-7 polynomial and Gray-to-level constellation mapping.
package qam_tpg_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_MAN   = 2'b01,
    MODE_SWEEP = 2'b10,
    MODE_PRBS  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_PRESENT = 2'd2
  } state_e;

  // x^7 + x^6 + 1, Fibonacci form: feedback from bits 6 and 5, shifted in at bit 0
  localparam logic [6:0] PRBS7_SEED   = 7'h7F;
  localparam int         PRBS7_TAP_HI = 6;
  localparam int         PRBS7_TAP_LO = 5;

  function automatic logic [6:0] prbs7_step(input logic [6:0] s);
    return {s[5:0], s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO]};
  endfunction

  // Fields up to 4 bits wide; narrower fields are zero-extended by the caller
  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    b[2] = g[3] ^ g[2];
    b[1] = g[3] ^ g[2] ^ g[1];
    b[0] = g[3] ^ g[2] ^ g[1] ^ g[0];
    return b;
  endfunction

  // Level index L maps to AMP*((2^k-1) - 2L): Gray 0 is the most positive point
  function automatic int level(input logic [3:0] g, input int k, input int amp);
    return amp * (((1 << k) - 1) - 2 * int'(gray2bin(g)));
  endfunction

endpackage

// File: rtl/qam_tick_gen.sv
// Free-running symbol tick: one-cycle pulse every TICK_DIV cycles, held at zero while clr is high.
// Tick is combinational from the counter; no backpressure, ticks are never queued.
module qam_tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int             W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0]   LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/qam_test_pattern_gen.sv
// Square M-QAM test-symbol source (manual / Gray sweep / PRBS-7) with reference bits; tick or man_load to sym_valid is 1 cycle,
// symbol held under backpressure with dropped ticks flagged in overrun. QAM_ERR_INJECT_EN adds periodic I-sign error injection.
module qam_test_pattern_gen
  import qam_tpg_pkg::*;
#(
  parameter int IQ_W         = 12,
  parameter int BITS_PER_SYM = 2,
  parameter int AMP          = 512,
  parameter int TICK_DIV     = 100_000_000,
  parameter int CNT_W        = 16
`ifdef QAM_ERR_INJECT_EN
  ,
  parameter int ERR_PERIOD   = 16
`endif
) (
  input  logic                    clk_100mhz,
  input  logic                    reset_btn_n,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic [BITS_PER_SYM-1:0] man_bits,
  input  logic                    man_load,
  input  logic                    sym_ready,
  output logic                    sym_valid,
  output logic signed [IQ_W-1:0]  i_out,
  output logic signed [IQ_W-1:0]  q_out,
  output logic [BITS_PER_SYM-1:0] ref_bits,
  output logic                    test_active,
  output logic [CNT_W-1:0]        sym_count,
  output logic                    overrun
`ifdef QAM_ERR_INJECT_EN
  ,
  output logic                    err_injected
`endif
);

  localparam int K       = BITS_PER_SYM / 2;
  localparam int MAX_LVL = AMP * ((1 << K) - 1);

  generate
    if (BITS_PER_SYM < 2 || BITS_PER_SYM > 8 || (BITS_PER_SYM % 2) != 0) begin : g_bad_bps
      $error("qam_test_pattern_gen: BITS_PER_SYM must be even and within 2..8");
    end
    if (MAX_LVL > (1 << (IQ_W - 1)) - 1) begin : g_bad_amp
      $error("qam_test_pattern_gen: AMP too large for IQ_W");
    end
    if (TICK_DIV < 1) begin : g_bad_div
      $error("qam_test_pattern_gen: TICK_DIV must be at least 1");
    end
  endgenerate

  state_e                    state;
  state_e                    state_nxt;
  logic [1:0]                mode_q;
  logic                      enable_q;
  logic                      act;
  logic                      clr;
  logic                      tick;
  logic                      load;
  logic                      accept;
  logic                      overrun_set;
  logic [BITS_PER_SYM-1:0]   n;
  logic [BITS_PER_SYM-1:0]   sym_bits;
  logic [BITS_PER_SYM-1:0]   prbs_bits;
  logic [6:0]                lfsr;
  logic [6:0]                lfsr_nxt;
  logic [3:0]                i_fld;
  logic [3:0]                q_fld;
  logic signed [IQ_W-1:0]    i_lvl;
  logic signed [IQ_W-1:0]    q_lvl;
  logic signed [IQ_W-1:0]    i_load;

  assign act = enable && (mode != MODE_OFF);
  // A mode change or enable falling abandons whatever is in flight
  assign clr = (mode != mode_q) || (enable_q && !enable);
  assign accept = sym_valid && sym_ready;
  assign load = (state == ST_WAIT) && !clr && ((mode == MODE_MAN) ? man_load : tick);
  assign overrun_set = (state == ST_PRESENT) && tick && !sym_ready && (mode != MODE_MAN);

  qam_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk_100mhz),
    .rst_n (reset_btn_n),
    .clr   (clr || !act),
    .tick  (tick)
  );

  always_ff @(posedge clk_100mhz) begin
    if (!reset_btn_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clr || !act) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    state_nxt = ST_WAIT;
        ST_WAIT:    if (load) state_nxt = ST_PRESENT;
        ST_PRESENT: if (sym_ready) state_nxt = ST_WAIT;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sym_valid = (state == ST_PRESENT);
  end

  // All BITS_PER_SYM LFSR steps unrolled; the first new bit ends up in the MSB
  always_comb begin
    lfsr_nxt  = lfsr;
    prbs_bits = '0;
    for (int s = 0; s < BITS_PER_SYM; s++) begin
      lfsr_nxt  = prbs7_step(lfsr_nxt);
      prbs_bits = {prbs_bits[BITS_PER_SYM-2:0], lfsr_nxt[0]};
    end
  end

  always_comb begin
    case (mode)
      MODE_MAN:   sym_bits = man_bits;
      MODE_SWEEP: sym_bits = n ^ (n >> 1);
      MODE_PRBS:  sym_bits = prbs_bits;
      default:    sym_bits = '0;
    endcase
  end

  always_comb begin
    i_fld = '0;
    q_fld = '0;
    i_fld[K-1:0] = sym_bits[K-1:0];
    q_fld[K-1:0] = sym_bits[2*K-1:K];
    i_lvl = IQ_W'(level(i_fld, K, AMP));
    q_lvl = IQ_W'(level(q_fld, K, AMP));
  end

`ifdef QAM_ERR_INJECT_EN
  localparam int EW = (ERR_PERIOD > 1) ? $clog2(ERR_PERIOD) : 1;

  logic [EW-1:0] pres_cnt;
  logic          err_now;

  assign err_now = (pres_cnt == EW'(ERR_PERIOD - 1));
  assign i_load  = err_now ? -i_lvl : i_lvl;

  always_ff @(posedge clk_100mhz) begin
    if (!reset_btn_n || clr) begin
      pres_cnt     <= '0;
      err_injected <= 1'b0;
    end else if (load) begin
      pres_cnt     <= err_now ? '0 : pres_cnt + EW'(1);
      err_injected <= err_now;
    end else if (accept) begin
      err_injected <= 1'b0;
    end
  end
`else
  assign i_load = i_lvl;
`endif

  always_ff @(posedge clk_100mhz) begin
    if (!reset_btn_n) begin
      mode_q      <= MODE_OFF;
      enable_q    <= 1'b0;
      test_active <= 1'b0;
      sym_count   <= '0;
      n           <= '0;
      overrun     <= 1'b0;
      lfsr        <= PRBS7_SEED;
      i_out       <= '0;
      q_out       <= '0;
      ref_bits    <= '0;
    end else begin
      mode_q      <= mode;
      enable_q    <= enable;
      test_active <= act;
      if (clr) begin
        sym_count <= '0;
        n         <= '0;
        overrun   <= 1'b0;
        lfsr      <= PRBS7_SEED;
        i_out     <= '0;
        q_out     <= '0;
        ref_bits  <= '0;
      end else begin
        if (accept) begin
          sym_count <= sym_count + CNT_W'(1);
          n         <= n + BITS_PER_SYM'(1);
        end
        if (overrun_set) begin
          overrun <= 1'b1;
        end
        if (load) begin
          ref_bits <= sym_bits;
          i_out    <= i_load;
          q_out    <= q_lvl;
          if (mode == MODE_PRBS) begin
            lfsr <= lfsr_nxt;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_qam_test_pattern_gen.sv
// Self-checking bench: QPSK instance (a) for reset/sweep/overrun/manual/PRBS, 16-QAM instance (b) for level mapping.
module tb_qam_test_pattern_gen;

  logic clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  logic        reset_btn_n;
  logic        enable;
  logic [1:0]  mode;
  logic [1:0]  man_bits;
  logic [3:0]  man_bits_b;
  logic        man_load;
  logic        sym_ready;

  logic               va, ta, oa;
  logic signed [11:0] ia, qa;
  logic [1:0]         ra;
  logic [15:0]        ca;
  logic               vb, tb_act, ob;
  logic signed [11:0] ib, qb;
  logic [3:0]         rb;
  logic [15:0]        cb;
`ifdef QAM_ERR_INJECT_EN
  logic err_a, err_b;
`endif

  qam_test_pattern_gen #(.IQ_W(12), .BITS_PER_SYM(2), .AMP(512), .TICK_DIV(4), .CNT_W(16)) dut_a (
    .clk_100mhz(clk_100mhz), .reset_btn_n(reset_btn_n), .enable(enable), .mode(mode),
    .man_bits(man_bits), .man_load(man_load), .sym_ready(sym_ready), .sym_valid(va),
    .i_out(ia), .q_out(qa), .ref_bits(ra), .test_active(ta), .sym_count(ca), .overrun(oa)
`ifdef QAM_ERR_INJECT_EN
    , .err_injected(err_a)
`endif
  );

  qam_test_pattern_gen #(.IQ_W(12), .BITS_PER_SYM(4), .AMP(256), .TICK_DIV(4), .CNT_W(16)) dut_b (
    .clk_100mhz(clk_100mhz), .reset_btn_n(reset_btn_n), .enable(enable), .mode(mode),
    .man_bits(man_bits_b), .man_load(man_load), .sym_ready(sym_ready), .sym_valid(vb),
    .i_out(ib), .q_out(qb), .ref_bits(rb), .test_active(tb_act), .sym_count(cb), .overrun(ob)
`ifdef QAM_ERR_INJECT_EN
    , .err_injected(err_b)
`endif
  );

  typedef struct {
    int refb;
    int i;
    int q;
  } exp_t;

  typedef struct {
    logic [1:0] bits;
    int         i;
    int         q;
  } man_vec_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_va(input int limit);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk_100mhz);
      if (va) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("wait_valid_a", int'(va), 1);
  endtask

  task automatic cmp_pop_a(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, sbq.size(), 1);
      return;
    end
    e = sbq.pop_front();
    chk({tag, "_ref"}, int'(ra), e.refb);
    chk({tag, "_i"}, int'(ia), e.i);
    chk({tag, "_q"}, int'(qa), e.q);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    man_vec_t man_tab[4];
    int       lvl_by_gray[4];
    logic [1:0] exp_ref[130];
    logic [1:0] got_ref[130];
    logic [6:0] s;
    logic [1:0] b;
    logic       fb;
    int         acc;
    int         hi, hq, hr;
    bit         held;
    logic [3:0] er;

    man_tab[0] = '{2'b00,  512,  512};
    man_tab[1] = '{2'b01, -512,  512};
    man_tab[2] = '{2'b11, -512, -512};
    man_tab[3] = '{2'b10,  512, -512};
    lvl_by_gray[0] = 768;
    lvl_by_gray[1] = 256;
    lvl_by_gray[3] = -256;
    lvl_by_gray[2] = -768;

    s = 7'h7F;
    for (int k = 0; k < 130; k++) begin
      b = 2'b00;
      for (int j = 0; j < 2; j++) begin
        fb = s[6] ^ s[5];
        s  = {s[5:0], fb};
        b  = {b[0], fb};
      end
      exp_ref[k] = b;
    end

    reset_btn_n = 1'b0;
    enable = 1'b1;
    mode = 2'b10;
    man_bits = 2'b00;
    man_bits_b = 4'h0;
    man_load = 1'b0;
    sym_ready = 1'b0;
    repeat (3) @(negedge clk_100mhz);
    chk("rst_valid", int'(va), 0);
    chk("rst_i", int'(ia), 0);
    chk("rst_q", int'(qa), 0);
    chk("rst_ref", int'(ra), 0);
    chk("rst_active", int'(ta), 0);
    chk("rst_count", int'(ca), 0);
    chk("rst_overrun", int'(oa), 0);

    // QPSK Gray sweep with continuous ready
    mode = 2'b00;
    enable = 1'b0;
    @(negedge clk_100mhz);
    reset_btn_n = 1'b1;
    enable = 1'b1;
    mode = 2'b10;
    sym_ready = 1'b1;
    sbq.push_back('{0,  512,  512});
    sbq.push_back('{1, -512,  512});
    sbq.push_back('{3, -512, -512});
    sbq.push_back('{2,  512, -512});
    sbq.push_back('{0,  512,  512});
    acc = 0;
    for (int c = 0; c < 200 && acc < 5; c++) begin
      @(negedge clk_100mhz);
      if (va && sym_ready) begin
        cmp_pop_a("sweep");
        chk("sweep_count", int'(ca), acc);
        acc++;
      end
    end
    if (acc < 5) chk("sweep_symbols", acc, 5);
    @(negedge clk_100mhz);
    chk("sweep_count_final", int'(ca), 5);
    chk("sweep_overrun", int'(oa), 0);
    chk("sweep_active", int'(ta), 1);
    sym_ready = 1'b0;

    // Backpressure: symbol held, ticks dropped, then resume at the next index
    sbq.push_back('{1, -512, 512});
    wait_va(20);
    hi = int'(ia); hq = int'(qa); hr = int'(ra);
    held = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_100mhz);
      if (!va || int'(ia) != hi || int'(qa) != hq || int'(ra) != hr) held = 1'b0;
    end
    chk("hold_stable", int'(held), 1);
    cmp_pop_a("hold");
    chk("hold_overrun", int'(oa), 1);
    sym_ready = 1'b1;
    @(negedge clk_100mhz);
    sym_ready = 1'b0;
    sbq.push_back('{3, -512, -512});
    wait_va(20);
    cmp_pop_a("resume");
    chk("resume_count", int'(ca), 6);

    // Reset while a symbol is pending
    reset_btn_n = 1'b0;
    @(negedge clk_100mhz);
    chk("midrst_valid", int'(va), 0);
    chk("midrst_i", int'(ia), 0);
    chk("midrst_q", int'(qa), 0);
    chk("midrst_ref", int'(ra), 0);
    chk("midrst_count", int'(ca), 0);
    chk("midrst_overrun", int'(oa), 0);

    // Manual mode: one-cycle latency, loads while presenting are ignored
    reset_btn_n = 1'b1;
    mode = 2'b01;
    repeat (3) @(negedge clk_100mhz);
    for (int r = 0; r < 4; r++) begin
      chk("man_idle_valid", int'(va), 0);
      man_bits = man_tab[r].bits;
      man_load = 1'b1;
      @(negedge clk_100mhz);
      man_load = 1'b0;
      chk("man_valid", int'(va), 1);
      chk("man_ref", int'(ra), int'(man_tab[r].bits));
      chk("man_i", int'(ia), man_tab[r].i);
      chk("man_q", int'(qa), man_tab[r].q);
      man_bits = ~man_tab[r].bits;
      man_load = 1'b1;
      @(negedge clk_100mhz);
      man_load = 1'b0;
      chk("man_ignored_ref", int'(ra), int'(man_tab[r].bits));
      sym_ready = 1'b1;
      @(negedge clk_100mhz);
      sym_ready = 1'b0;
      @(negedge clk_100mhz);
    end
    chk("man_count", int'(ca), 4);
    chk("man_overrun", int'(oa), 0);

    // PRBS-7 against the reference LFSR, plus 127-symbol periodicity
    mode = 2'b11;
    sym_ready = 1'b1;
    acc = 0;
    for (int c = 0; c < 1000 && acc < 130; c++) begin
      @(negedge clk_100mhz);
      if (va && sym_ready) begin
        got_ref[acc] = ra;
        chk("prbs_ref", int'(ra), int'(exp_ref[acc]));
        chk("prbs_i", int'(ia), exp_ref[acc][0] ? -512 : 512);
        chk("prbs_q", int'(qa), exp_ref[acc][1] ? -512 : 512);
        acc++;
      end
    end
    if (acc < 130) chk("prbs_symbols", acc, 130);
    for (int k = 0; k < 3 && acc == 130; k++) begin
      chk("prbs_period", int'(got_ref[k + 127]), int'(got_ref[k]));
    end

    // Re-entering PRBS mode reseeds the LFSR
    mode = 2'b10;
    repeat (2) @(negedge clk_100mhz);
    mode = 2'b11;
    acc = 0;
    for (int c = 0; c < 100 && acc < 2; c++) begin
      @(negedge clk_100mhz);
      if (va && sym_ready) begin
        chk("prbs_reseed_ref", int'(ra), int'(exp_ref[acc]));
        acc++;
      end
    end
    if (acc < 2) chk("prbs_reseed_symbols", acc, 2);

    // 16-QAM sweep on instance b, then mode switch clears the count
    mode = 2'b10;
    acc = 0;
    for (int c = 0; c < 200 && acc < 8; c++) begin
      @(negedge clk_100mhz);
      if (vb && sym_ready) begin
        er = 4'(acc) ^ (4'(acc) >> 1);
        chk("qam16_ref", int'(rb), int'(er));
        chk("qam16_i", int'(ib), lvl_by_gray[er[1:0]]);
        chk("qam16_q", int'(qb), lvl_by_gray[er[3:2]]);
        chk("qam16_count", int'(cb), acc);
        acc++;
      end
    end
    if (acc < 8) chk("qam16_symbols", acc, 8);
    @(negedge clk_100mhz);
    chk("qam16_count_pre_switch", int'(cb), 8);
    mode = 2'b11;
    @(negedge clk_100mhz);
    chk("switch_count", int'(cb), 0);
    chk("switch_valid", int'(vb), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
